// File: rtl/ofram_access_ctrl.sv
// Burst access controller for an asynchronous SRAM-style RAM port.
// Writes are sequenced as setup/pulse/hold; reads as access/response.
module ofram_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int WR_PULSE   = 2,
    parameter int RD_WAIT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_len,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  wdata_ack,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_ACCESS,
        R_RESP,
        DONE
    } state_t;

    localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);
    localparam logic [7:0] RD_LAST = 8'(RD_WAIT - 1);

    state_t                state;
    logic [3:0]            beat_cnt;
    logic [7:0]            tmr;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  drive;
    logic                  we_q;

    assign ram_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            tmr         <= '0;
            wdata_q     <= '0;
            drive       <= 1'b0;
            we_q        <= 1'b0;
            req_ready   <= 1'b0;
            wdata_ack   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_address <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
        end else begin
            wdata_ack <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        we_q        <= req_we;
                        ram_address <= req_addr;
                        beat_cnt    <= req_len;
                        ram_cs      <= 1'b1;
                        ram_we      <= 1'b0;
                        if (req_we) begin
                            state   <= W_SETUP;
                            wdata_q <= req_wdata;
                            drive   <= 1'b1;
                            ram_oe  <= 1'b0;
                        end else begin
                            state  <= R_ACCESS;
                            drive  <= 1'b0;
                            ram_oe <= 1'b1;
                            tmr    <= RD_LAST;
                        end
                    end
                end
                W_SETUP: begin
                    state  <= W_PULSE;
                    ram_we <= 1'b1;
                    tmr    <= WR_LAST;
                end
                W_PULSE: begin
                    if (tmr == 8'd0) begin
                        state     <= W_HOLD;
                        ram_we    <= 1'b0;
                        wdata_ack <= 1'b1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                R_ACCESS: begin
                    if (tmr == 8'd0) begin
                        state     <= R_RESP;
                        rsp_rdata <= ram_data;
                        rsp_valid <= 1'b1;
                        ram_cs    <= 1'b0;
                        ram_oe    <= 1'b0;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                W_HOLD, R_RESP: begin
                    // a beat ends after the write hold or the read handshake
                    if (state == W_HOLD || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (beat_cnt == 4'd0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            ram_cs <= 1'b0;
                            drive  <= 1'b0;
                        end else begin
                            beat_cnt    <= beat_cnt - 4'd1;
                            ram_address <= ram_address + 1'b1;
                            ram_cs      <= 1'b1;
                            if (we_q) begin
                                state   <= W_SETUP;
                                wdata_q <= req_wdata;
                                drive   <= 1'b1;
                            end else begin
                                state  <= R_ACCESS;
                                ram_oe <= 1'b1;
                                tmr    <= RD_LAST;
                            end
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofram_access_ctrl.sv
// Directed and randomized bursts against a cycle-schedule reference.
// The RAM device model sits on the shared data bus.
module tb_ofram_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int WR = 2;
    localparam int RD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_len = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          wdata_ack;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    wire  [DW-1:0] ram_data;

    always #5 clk = ~clk;

    ofram_access_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .WR_PULSE  (WR),
        .RD_WAIT   (RD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .wdata_ack  (wdata_ack),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .done       (done),
        .ram_address(ram_address),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_oe     (ram_oe),
        .ram_data   (ram_data)
    );

    // RAM device: latches on the clock while strobed, drives when enabled
    logic [DW-1:0] mem [64];
    assign ram_data = (ram_cs && ram_oe) ? mem[ram_address] : 'z;
    always @(posedge clk)
        if (ram_cs && ram_we) mem[ram_address] <= ram_data;

    typedef struct packed {
        logic          cs;
        logic          we;
        logic          oe;
        logic          ack;
        logic          rv;
        logic          dn;
        logic          bsy;
        logic          rdy_drv;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
        logic [DW-1:0] wd_drv;
    } rec_t;

    rec_t          q[$];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] wd [16];
    int            st [16];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        assert (!(ram_we && ram_oe)) else begin
            errors++;
            $error("FAIL inv_we_oe: observed we=%b oe=%b expected not both", ram_we, ram_oe);
        end
        checks++;
        assert (!((ram_we || ram_oe) && !ram_cs)) else begin
            errors++;
            $error("FAIL inv_cs: observed cs=%b we=%b oe=%b expected strobes only with cs",
                   ram_cs, ram_we, ram_oe);
        end
    end

    // Expected per-cycle schedule: each write beat is setup, WR pulse
    // cycles and one hold cycle; the final cycle is the done pulse.
    task automatic gen_write(input int addr, input int len);
        rec_t          r;
        logic [AW-1:0] a;
        for (int b = 0; b <= len; b++) begin
            a = AW'((addr + b) % 64);
            for (int p = 0; p <= WR + 1; p++) begin
                r = '0;
                r.cs = 1'b1;
                r.we = (p >= 1 && p <= WR);
                r.ack = (p == WR + 1);
                r.bsy = 1'b1;
                r.addr = a;
                r.wdat = wd[b];
                r.wd_drv = (p == WR + 1 && b < len) ? wd[b + 1] : DW'($urandom);
                q.push_back(r);
            end
            ref_mem[a] = wd[b];
        end
        r = '0;
        r.dn = 1'b1;
        q.push_back(r);
    endtask

    task automatic gen_read(input int addr, input int len);
        rec_t          r;
        logic [AW-1:0] a;
        for (int b = 0; b <= len; b++) begin
            a = AW'((addr + b) % 64);
            for (int p = 0; p < RD; p++) begin
                r = '0;
                r.cs = 1'b1;
                r.oe = 1'b1;
                r.bsy = 1'b1;
                r.addr = a;
                r.rdy_drv = 1'($urandom);
                q.push_back(r);
            end
            for (int k = 0; k <= st[b]; k++) begin
                r = '0;
                r.rv = 1'b1;
                r.bsy = 1'b1;
                r.rdat = ref_mem[a];
                r.rdy_drv = (k == st[b]);
                q.push_back(r);
            end
        end
        r = '0;
        r.dn = 1'b1;
        q.push_back(r);
    endtask

    task automatic run(input logic we, input int addr, input int len);
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_we = we;
        req_addr = AW'(addr);
        req_len = 4'(len);
        req_wdata = wd[0];
        rsp_ready = 1'b0;
        @(posedge clk);
        foreach (q[i]) begin
            @(negedge clk);
            req_valid = (i == q.size() - 1) ? 1'b0 : 1'($urandom);
            req_we = 1'($urandom);
            req_addr = AW'($urandom);
            req_len = 4'($urandom);
            chk("ctl", 64'({ram_cs, ram_we, ram_oe, wdata_ack, rsp_valid, done, busy}),
                64'({q[i].cs, q[i].we, q[i].oe, q[i].ack, q[i].rv, q[i].dn, q[i].bsy}));
            if (q[i].cs) chk("addr", 64'(ram_address), 64'(q[i].addr));
            if (q[i].cs && !q[i].oe) chk("wdata", 64'(ram_data), 64'(q[i].wdat));
            if (q[i].rv) chk("rdata", 64'(rsp_rdata), 64'(q[i].rdat));
            rsp_ready = q[i].rdy_drv;
            req_wdata = q[i].wd_drv;
        end
        @(negedge clk);
        chk("idle_after", 64'({req_ready, busy, done}), 64'(3'b100));
        q.delete();
    endtask

    task automatic no_stall();
        for (int i = 0; i < 16; i++) st[i] = 0;
    endtask

    initial begin
        int a;
        int l;
        #12;
        chk("rst_ctl", 64'({req_ready, ram_cs, ram_we, ram_oe, rsp_valid,
                            wdata_ack, busy, done}), 64'(0));
        chk("rst_addr", 64'(ram_address), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'(1));

        no_stall();
        wd[0] = 32'hDEADBEEF;
        gen_write(5, 0);
        run(1'b1, 5, 0);
        gen_read(5, 0);
        run(1'b0, 5, 0);

        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        gen_write(62, 3);
        run(1'b1, 62, 3);

        st[0] = 5;
        gen_read(62, 1);
        run(1'b0, 62, 1);
        no_stall();

        for (int i = 0; i < 3; i++) wd[i] = $urandom;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 6'd10;
        req_len = 4'd2;
        req_wdata = wd[0];
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_setup_cs", 64'(ram_cs), 64'(1));
        @(posedge clk);
        #2;
        chk("mid_pulse_we", 64'(ram_we), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 64'({req_ready, ram_cs, ram_we, ram_oe, busy, done}), 64'(0));
        chk("mid_rst_addr", 64'(ram_address), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_rst", 64'({ram_cs, ram_we, done, busy}), 64'(0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst", 64'({req_ready, ram_cs, done, busy}), 64'(4'b1000));
        end

        gen_write(10, 2);
        run(1'b1, 10, 2);
        gen_read(10, 2);
        run(1'b0, 10, 2);

        for (int n = 0; n < 6; n++) begin
            a = int'($urandom_range(63, 0));
            l = int'($urandom_range(3, 0));
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                st[i] = int'($urandom_range(3, 0));
            end
            gen_write(a, l);
            run(1'b1, a, l);
            gen_read(a, l);
            run(1'b0, a, l);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
